// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: valid/ready in, valid/ready out.
// Master drives operands and out_ready; slave returns in_ready and the registered result.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               carry;
  logic               err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, err
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ALU: ADD/SUB/logic valid 1 edge after accept, MUL/DIV after WIDTH+1.
// Result is held in DONE until out_ready; in_ready is low from accept until the output handshake.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;

  // work_q doubles as the result register: {hi, lo} for MUL, {rem, quot} for DIV.
  always_comb begin
    add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
    div_sh    = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, opnd_q};
    // Shifted remainder is below 2*divisor, so the trial's top bit is exactly the borrow.
    div_ge    = ~div_trial[WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    carry_d = carry_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          carry_d = 1'b0;
          err_d   = 1'b0;
          state_d = DONE;
          case (bus.op)
            OP_ADD: begin
              work_d  = {{(WIDTH-1){1'b0}}, add_sum};
              carry_d = add_sum[WIDTH];
            end
            OP_SUB: begin
              work_d  = {{WIDTH{1'b0}}, bus.a - bus.b};
              carry_d = (bus.a < bus.b);
            end
            OP_MUL: begin
              work_d  = {{WIDTH{1'b0}}, bus.b};
              opnd_d  = bus.a;
              div_d   = 1'b0;
              cnt_d   = CW'(WIDTH);
              state_d = BUSY;
            end
            OP_DIV: begin
              if (bus.b == '0) begin
                work_d = {bus.a, {WIDTH{1'b1}}};
                err_d  = 1'b1;
              end else begin
                work_d  = {{WIDTH{1'b0}}, bus.a};
                opnd_d  = bus.b;
                div_d   = 1'b1;
                cnt_d   = CW'(WIDTH);
                state_d = BUSY;
              end
            end
            OP_AND:  work_d = {{WIDTH{1'b0}}, bus.a & bus.b};
            OP_OR:   work_d = {{WIDTH{1'b0}}, bus.a | bus.b};
            OP_XOR:  work_d = {{WIDTH{1'b0}}, bus.a ^ bus.b};
            default: begin
              work_d = '0;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        if (div_q) begin
          work_d = {(div_ge ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                    work_q[WIDTH-2:0], div_ge};
        end else begin
          work_d = {mul_sum, work_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = work_q;
  assign bus.carry     = carry_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): expected results queued at issue, checked on output.
module tb_seq_alu;
  localparam int W = 8;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           c;
    logic           e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [2*W-1:0] res, input logic c, input logic e);
    exp_t r;
    r.res = res;
    r.c   = c;
    r.e   = e;
    return r;
  endfunction

  // Behavioural reference built on the language's own arithmetic operators.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t           r;
    logic [2*W-1:0] wa;
    logic [2*W-1:0] wb;
    r  = '0;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    case (op)
      3'd0: begin r.res = wa + wb; r.c = r.res[W]; end
      3'd1: begin r.res = {{W{1'b0}}, a - b}; r.c = (a < b); end
      3'd2: r.res = wa * wb;
      3'd3: begin
        if (b == '0) begin r.res = {a, {W{1'b1}}}; r.e = 1'b1; end
        else r.res = {a % b, a / b};
      end
      3'd4: r.res = wa & wb;
      3'd5: r.res = wa | wb;
      3'd6: r.res = wa ^ wb;
      default: r.e = 1'b1;
    endcase
    return r;
  endfunction

  // Issue one op with out_ready already high; check latency, busy in_ready, result, return to idle.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input int lat, input string tag);
    int   n;
    exp_t x;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    while (!bus.out_valid && n < 64) begin
      chk({tag, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({tag, "_result"}, 32'(bus.result), 32'(x.res));
      chk({tag, "_carry"}, 32'(bus.carry), 32'(x.c));
      chk({tag, "_err"}, 32'(bus.err), 32'(x.e));
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int          hits;
    exp_t        x;
    logic [2:0]  rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    do_op(3'd0, 8'd200, 8'd100, mk(16'h012C, 1'b1, 1'b0), 1, "add_200_100");
    do_op(3'd1, 8'd5, 8'd7, mk(16'h00FE, 1'b1, 1'b0), 1, "sub_5_7");
    do_op(3'd1, 8'd7, 8'd5, mk(16'h0002, 1'b0, 1'b0), 1, "sub_7_5");
    do_op(3'd2, 8'd255, 8'd255, mk(16'hFE01, 1'b0, 1'b0), W + 1, "mul_255_255");
    do_op(3'd2, 8'd0, 8'd37, mk(16'h0000, 1'b0, 1'b0), W + 1, "mul_0_37");
    do_op(3'd3, 8'd100, 8'd7, mk(16'h020E, 1'b0, 1'b0), W + 1, "div_100_7");
    do_op(3'd3, 8'd9, 8'd0, mk(16'h09FF, 1'b0, 1'b1), 1, "div_9_0");
    do_op(3'd4, 8'hF0, 8'h3C, mk(16'h0030, 1'b0, 1'b0), 1, "and");
    do_op(3'd5, 8'hF0, 8'h3C, mk(16'h00FC, 1'b0, 1'b0), 1, "or");
    do_op(3'd6, 8'hF0, 8'h3C, mk(16'h00CC, 1'b0, 1'b0), 1, "xor");
    do_op(3'd3, 8'd7, 8'd200, mk(16'h0700, 1'b0, 1'b0), W + 1, "div_7_200");

    // Backpressure: result held, in_ready low, extra in_valid pulses ignored
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.op = 3'd0; bus.a = 8'd1; bus.b = 8'd1; bus.in_valid = 1'b1;
    sb.push_back(mk(16'h0002, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", 32'(bus.result), 32'h0002);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = (i % 2 == 0);
      bus.op = 3'd2; bus.a = 8'd9; bus.b = 8'd9;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    x = sb.pop_front();
    chk("bp_sb_result", 32'(bus.result), 32'(x.res));
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    hits = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) hits++;
    end
    chk("bp_single_handshake", 32'(hits), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset sampled at edge 4 of a MUL: operation dropped
    @(negedge clk);
    bus.op = 3'd2; bus.a = 8'd13; bus.b = 8'd11; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_result", 32'(bus.result), 32'd0);
    hits = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) hits++;
    end
    chk("midrst_no_output", 32'(hits), 32'd0);
    do_op(3'd7, 8'd3, 8'd4, mk(16'h0000, 1'b0, 1'b1), 1, "reserved_op");

    // Extra vectors against the behavioural model
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra  = W'($urandom);
      rb  = (i == 3) ? '0 : W'($urandom);
      if (i == 2) rop = 3'd3;
      if (i == 3) rop = 3'd3;
      do_op(rop, ra, rb, model(rop, ra, rb),
            (rop == 3'd2 || (rop == 3'd3 && rb != '0)) ? W + 1 : 1, "model");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
